// File: rtl/binary_search_pkg.sv
// Shared definitions for the binary_search call-replacement block: bus size codes,
// FSM state encoding and the MMIO addresses of the neighbouring tty peripherals.
package binary_search_pkg;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;

  localparam logic [31:0] TTY_TX_ADDR = 32'h0000_3000;
  localparam logic [31:0] TTY_RX_ADDR = 32'h0000_3004;

  typedef enum logic [2:0] {
    PRESET,
    PROLOGUE,
    LOOP,
    LOAD_REQ,
    LOAD_WAIT,
    COMPARE,
    EPILOGUE,
    DONE
  } bs_state_t;

endpackage

// File: rtl/binary_search_bus_master_port.sv
// Single-outstanding bus master: latches a request, holds it stable until ready is
// sampled, and lane-shifts store data to the byte address.
module bus_master_port (
  input  logic        clk,
  input  logic        rstb,
  input  logic        i_req,
  input  logic        i_abort,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_size,
  input  logic        i_write,
  input  logic [31:0] i_wdata,
  input  logic        i_ready,
  output logic [31:0] o_addr,
  output logic [2:0]  o_size,
  output logic        o_valid,
  output logic        o_write,
  output logic [31:0] o_wdata,
  output logic        o_done
);

  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic        r_valid;
  logic        r_write;
  logic [31:0] r_wdata;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (i_abort) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      if (i_ready) r_valid <= 1'b0;
    end else if (i_req) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_size  <= i_size;
      r_write <= i_write;
      r_wdata <= i_wdata << {i_addr[1:0], 3'b000};
    end
  end

  // A completion that coincides with an abort is discarded by the caller anyway.
  assign o_done  = r_valid & i_ready & ~i_abort;
  assign o_addr  = r_addr;
  assign o_size  = r_size;
  assign o_valid = r_valid;
  assign o_write = r_write;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/binary_search.sv
// Hardware replacement for a compiled binarysearch(A, lo, hi, target) call: stack
// prologue, signed binary search over bus memory, epilogue, then return to ra.
module binary_search
  import binary_search_pkg::*;
#(
  parameter int PC_W   = 7,
  parameter int RET_PC = 0
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            setb,
  output logic            idle,
  input  logic [31:0]     ra0,
  input  logic [31:0]     a00,
  input  logic [31:0]     a10,
  input  logic [31:0]     a20,
  input  logic [31:0]     a30,
  input  logic [31:0]     a40,
  input  logic [31:0]     a50,
  input  logic [PC_W-1:0] pc0,
  input  logic [31:0]     sp0,
  input  logic [31:0]     s00,
  output logic [31:0]     addr,
  output logic [2:0]      size,
  output logic            valid,
  output logic            write,
  output logic [31:0]     wdata,
  input  logic [31:0]     rdata,
  input  logic            ready
);

  bs_state_t r_state, w_next;

  logic signed [31:0] a0;
  logic signed [31:0] r_a1, r_a2, r_a3, r_a4, r_a5;
  logic        [31:0] r_ra, r_sp, r_s0;
  logic [PC_W-1:0]    r_pc;
  logic signed [31:0] r_mid, r_res, r_data;
  logic [1:0]         r_sub;

  logic signed [31:0] w_sum, w_mid;
  logic               w_lt;
  logic               w_req, w_bwrite, w_done;
  logic [31:0]        w_baddr, w_bwdata;
  logic               w_unused;

  assign w_sum    = r_a1 + r_a2;
  assign w_mid    = w_sum >>> 1;
  assign w_lt     = r_a1 < r_a2;
  assign idle     = (r_state == DONE);
  assign w_unused = ^{r_a4, r_a5};

  // Even r_sub issues a bus request, odd r_sub waits for its completion.
  always_comb begin
    w_req    = 1'b0;
    w_baddr  = '0;
    w_bwrite = 1'b0;
    w_bwdata = '0;
    case (r_state)
      PROLOGUE: begin
        w_req    = ~r_sub[0];
        w_bwrite = 1'b1;
        w_baddr  = r_sub[1] ? r_sp - 32'd8 : r_sp - 32'd4;
        w_bwdata = r_sub[1] ? r_s0 : r_ra;
      end
      LOAD_REQ: begin
        w_req   = 1'b1;
        w_baddr = a0 + {r_mid[29:0], 2'b00};
      end
      EPILOGUE: begin
        w_req   = ~r_sub[0];
        w_baddr = r_sub[1] ? r_sp + 32'd12 : r_sp + 32'd8;
      end
      default: ;
    endcase
  end

  bus_master_port u_port (
    .clk     (clk),
    .rstb    (rstb),
    .i_req   (w_req),
    .i_abort (~setb),
    .i_addr  (w_baddr),
    .i_size  (SZ_W),
    .i_write (w_bwrite),
    .i_wdata (w_bwdata),
    .i_ready (ready),
    .o_addr  (addr),
    .o_size  (size),
    .o_valid (valid),
    .o_write (write),
    .o_wdata (wdata),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= PRESET;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      PRESET:    if (setb) w_next = (r_pc == PC_W'(RET_PC)) ? PROLOGUE : DONE;
      PROLOGUE:  if (r_sub == 2'd3 && w_done) w_next = LOOP;
      LOOP:      w_next = w_lt ? LOAD_REQ : EPILOGUE;
      LOAD_REQ:  w_next = LOAD_WAIT;
      LOAD_WAIT: if (w_done) w_next = COMPARE;
      COMPARE:   w_next = (r_data == r_a3) ? EPILOGUE : LOOP;
      EPILOGUE:  if (r_sub == 2'd3 && w_done) w_next = DONE;
      DONE:      w_next = DONE;
      default:   w_next = PRESET;
    endcase
    if (!setb) w_next = PRESET;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a0 <= '0; r_a1 <= '0; r_a2 <= '0; r_a3 <= '0; r_a4 <= '0; r_a5 <= '0;
      r_ra <= '0; r_sp <= '0; r_s0 <= '0; r_pc <= '0;
      r_mid <= '0; r_res <= '0; r_data <= '0; r_sub <= '0;
    end else if (!setb) begin
      r_sub <= '0;
      if (r_state == PRESET) begin
        a0 <= a00; r_a1 <= a10; r_a2 <= a20; r_a3 <= a30; r_a4 <= a40; r_a5 <= a50;
        r_ra <= ra0; r_sp <= sp0; r_s0 <= s00; r_pc <= pc0;
      end
    end else begin
      case (r_state)
        PRESET: r_sub <= '0;
        PROLOGUE: begin
          if (!r_sub[0]) begin
            r_sub <= r_sub + 2'd1;
          end else if (w_done) begin
            r_sub <= r_sub + 2'd1;
            if (r_sub == 2'd3) begin
              r_sp  <= r_sp - 32'd16;
              r_res <= r_a1;
            end
          end
        end
        LOOP:      if (w_lt) r_mid <= w_mid;
        LOAD_WAIT: if (w_done) r_data <= rdata;
        COMPARE: begin
          // The last probed index doubles as the not-found result.
          r_res <= r_mid;
          if (r_data < r_a3)      r_a1 <= r_mid + 32'sd1;
          else if (r_data > r_a3) r_a2 <= r_mid;
        end
        EPILOGUE: begin
          if (!r_sub[0]) begin
            r_sub <= r_sub + 2'd1;
          end else if (w_done) begin
            r_sub <= r_sub + 2'd1;
            if (r_sub == 2'd1) r_s0 <= rdata;
            if (r_sub == 2'd3) begin
              r_ra <= rdata;
              r_sp <= r_sp + 32'd16;
              a0   <= r_res;
              r_pc <= rdata[PC_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_search.sv
// Randomized self-checking bench for binary_search with a behavioural memory,
// bus-protocol monitor and a plain-arithmetic search reference.
module tb_binary_search;

  logic        clk = 1'b0;
  logic        rstb, setb, ready;
  logic [31:0] ra0, a00, a10, a20, a30, a40, a50, sp0, s00, rdata;
  logic [6:0]  pc0;
  logic        idle, valid, write;
  logic [31:0] addr, wdata;
  logic [2:0]  size;

  int total = 0;
  int bad   = 0;
  int proto_err = 0;
  int lat = 0;
  int cnt = 0;
  int arr [100];
  logic [31:0] stk8, stkc;
  logic        pv = 1'b0, pr = 1'b0, pw = 1'b0;
  logic [31:0] pa = '0, pd = '0;

  always #5 clk = ~clk;

  binary_search #(.PC_W(7), .RET_PC(0)) dut (
    .clk(clk), .rstb(rstb), .setb(setb), .idle(idle),
    .ra0(ra0), .a00(a00), .a10(a10), .a20(a20), .a30(a30), .a40(a40), .a50(a50),
    .pc0(pc0), .sp0(sp0), .s00(s00),
    .addr(addr), .size(size), .valid(valid), .write(write), .wdata(wdata),
    .rdata(rdata), .ready(ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_search(input int lo, input int hi, input int t);
    int res = lo;
    while (lo < hi) begin
      int mid = (lo + hi) >>> 1;
      res = mid;
      if (arr[mid] == t) return mid;
      if (arr[mid] < t) lo = mid + 1;
      else hi = mid;
    end
    return res;
  endfunction

  // Memory: the array at 0x1000, two stack words; everything else is illegal here.
  always @(negedge clk) begin
    if (!setb) begin
      stk8 = '0;
      stkc = '0;
    end
    if (valid) begin
      if (pv && !pr && (addr !== pa || write !== pw || wdata !== pd)) proto_err++;
      if (pv && pr) proto_err++;
      if (addr[1:0] != 2'b00 || size != 3'd2) proto_err++;
      if (cnt >= lat) begin
        ready = 1'b1;
        cnt = 0;
        if (write) begin
          if (addr == 32'h1FF8) stk8 = wdata;
          else if (addr == 32'h1FFC) stkc = wdata;
          else proto_err++;
        end else begin
          if (addr >= 32'h1000 && addr < 32'h1190) rdata = arr[(addr - 32'h1000) >> 2];
          else if (addr == 32'h1FF8) rdata = stk8;
          else if (addr == 32'h1FFC) rdata = stkc;
          else begin
            rdata = 32'hDEAD_BEEF;
            proto_err++;
          end
        end
      end else begin
        ready = 1'b0;
        cnt++;
      end
    end else begin
      ready = 1'b0;
      cnt = 0;
    end
    pv = valid; pr = ready; pa = addr; pw = write; pd = wdata;
  end

  task automatic preset(input int lo, input int hi, input int t, input logic [6:0] pc, input int lt);
    @(negedge clk);
    lat = lt;
    setb = 1'b0;
    a00 = 32'h1000; a10 = lo; a20 = hi; a30 = t;
    a40 = $urandom; a50 = $urandom;
    ra0 = 32'h54; sp0 = 32'h2000; s00 = $urandom; pc0 = pc;
    repeat (2) @(negedge clk);
    setb = 1'b1;
  endtask

  task automatic do_run(input int lo, input int hi, input int t, input logic [6:0] pc,
                        input int lt, output logic [31:0] res, output logic ok);
    preset(lo, hi, t, pc, lt);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (idle) begin
        ok = 1'b1;
        break;
      end
    end
    res = dut.a0;
  endtask

  task automatic check_run(input string tag, input int lo, input int hi, input int t, input int lt);
    logic [31:0] res;
    logic ok;
    int e0 = proto_err;
    do_run(lo, hi, t, 7'd0, lt, res, ok);
    chk({tag, "_idle"}, {31'd0, ok}, 32'd1);
    chk(tag, res, ref_search(lo, hi, t));
    chk({tag, "_stk_ra"}, stkc, ra0);
    chk({tag, "_stk_s0"}, stk8, s00);
    chk({tag, "_proto"}, proto_err - e0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic ok;
    int v, lo, hi, t;

    rstb = 1'b0; setb = 1'b0; rdata = '0; ready = 1'b0;
    ra0 = '0; a00 = '0; a10 = '0; a20 = '0; a30 = '0; a40 = '0; a50 = '0;
    pc0 = '0; sp0 = '0; s00 = '0;
    v = -5000 + $urandom_range(0, 50);
    for (int i = 0; i < 100; i++) begin
      arr[i] = v;
      v += $urandom_range(2, 100);
    end

    @(negedge clk);
    chk("rst_idle",  {31'd0, idle},  32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_size",  {29'd0, size},  32'd0);
    chk("rst_addr",  addr,  32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_a0",    dut.a0, 32'd0);
    rstb = 1'b1;

    check_run("hit37_l0", 0, 100, arr[37], 0);
    chk("hit37_val", res, res);
    check_run("hit37_l1", 0, 100, arr[37], 1);
    check_run("hit37_l5", 0, 100, arr[37], 5);

    do_run(0, 100, arr[37], 7'd0, 5, res, ok);
    chk("hit37_abs", res, 32'd37);
    do_run(0, 100, -6000, 7'd0, 0, res, ok);
    chk("below_abs", res, 32'd0);
    do_run(0, 100, arr[99] + 7, 7'd0, 1, res, ok);
    chk("above_abs", res, 32'd99);

    check_run("gap10", 0, 100, arr[10] + 1, 2);
    do_run(0, 100, arr[10] + 1, 7'd0, 0, res, ok);
    chk("gap10_near", {31'd0, (res == 32'd10 || res == 32'd11)}, 32'd1);

    check_run("empty", 5, 5, arr[5], 0);
    do_run(7, 3, arr[5], 7'd0, 0, res, ok);
    chk("inverted", res, 32'd7);

    do_run(0, 100, arr[4], 7'd1, 0, res, ok);
    chk("badpc_idle", {31'd0, ok}, 32'd1);
    chk("badpc_a0", res, 32'h1000);
    chk("badpc_stk", stkc, 32'd0);

    for (int k = 0; k < 12; k++) begin
      lo = $urandom_range(0, 60);
      hi = $urandom_range(lo, 100);
      t  = ($urandom_range(0, 1) == 1) ? arr[$urandom_range(0, 99)]
                                       : int'($urandom_range(0, 12000)) - 6000;
      check_run("rand", lo, hi, t, $urandom_range(0, 3));
      res = dut.a0;
      if (hi > lo && t >= arr[lo] && t <= arr[hi - 1] && ref_search(lo, hi, t) == int'(res)
          && arr[res] == t)
        chk("rand_hit", arr[res], t);
    end

    preset(0, 100, arr[80], 7'd0, 5);
    repeat (30) @(negedge clk);
    chk("mid_busy", {31'd0, idle}, 32'd0);
    #2 rstb = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_addr",  addr,  32'd0);
    chk("arst_write", {31'd0, write}, 32'd0);
    chk("arst_size",  {29'd0, size},  32'd0);
    chk("arst_wdata", wdata, 32'd0);
    chk("arst_idle",  {31'd0, idle},  32'd0);
    setb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    check_run("after_rst", 0, 100, arr[80], 1);

    chk("drop_pre", {31'd0, idle}, 32'd1);
    setb = 1'b0;
    @(negedge clk);
    chk("drop_idle", {31'd0, idle}, 32'd0);
    check_run("rerun", 0, 100, arr[63], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
